// File: rtl/fp32_pkg.sv
// rtl/fp32_pkg.sv - shared binary32 constants, operand classes and classifier
package fp32_pkg;

  localparam int DWIDTH = 32;
  localparam int EWIDTH = 8;
  localparam int MWIDTH = 23;
  localparam int BIAS   = 127;

  localparam logic [EWIDTH-1:0] EXP_MAX = 8'hFF;
  localparam logic [DWIDTH-1:0] QNAN    = 32'h7FC00000;

  typedef enum logic [1:0] {ZERO, NORM, INF, NAN} op_class_e;

  // Subnormals fold into ZERO: this datapath never produces or consumes them.
  function automatic op_class_e classify(input logic [EWIDTH-1:0] e,
                                         input logic [MWIDTH-1:0] f);
    if (e == '0)           return ZERO;
    else if (e != EXP_MAX) return NORM;
    else if (f == '0)      return INF;
    else                   return NAN;
  endfunction

endpackage

// File: rtl/booth_mul_24x24.sv
// rtl/booth_mul_24x24.sv - combinational radix-4 Booth unsigned 24x24 -> 48 multiplier
module booth_mul_24x24 (
  input  logic [23:0] i_a,
  input  logic [23:0] i_b,
  output logic [47:0] o_p
);

  // Two zero bits on top keep the last Booth digit non-negative for unsigned i_b.
  logic [26:0] w_bx;
  logic [47:0] w_a48;
  logic [47:0] w_pp [13];
  logic [47:0] w_l1 [7];
  logic [47:0] w_l2 [4];
  logic [47:0] w_l3 [2];

  assign w_bx  = {2'b00, i_b, 1'b0};
  assign w_a48 = {24'd0, i_a};

  always_comb begin
    for (int i = 0; i < 13; i++) begin
      case (w_bx[2*i +: 3])
        3'b001, 3'b010: w_pp[i] = w_a48 << (2*i);
        3'b011:         w_pp[i] = (w_a48 << 1) << (2*i);
        3'b100:         w_pp[i] = (-(w_a48 << 1)) << (2*i);
        3'b101, 3'b110: w_pp[i] = (-w_a48) << (2*i);
        default:        w_pp[i] = '0;
      endcase
    end
  end

  // Balanced reduction 13 -> 7 -> 4 -> 2 -> 1; modulo-2^48 arithmetic is exact here.
  always_comb begin
    for (int j = 0; j < 6; j++) w_l1[j] = w_pp[2*j] + w_pp[2*j+1];
    w_l1[6] = w_pp[12];
    for (int k = 0; k < 3; k++) w_l2[k] = w_l1[2*k] + w_l1[2*k+1];
    w_l2[3] = w_l1[6];
    w_l3[0] = w_l2[0] + w_l2[1];
    w_l3[1] = w_l2[2] + w_l2[3];
  end

  assign o_p = w_l3[0] + w_l3[1];

endmodule

// File: rtl/fp32_booth_mul.sv
// rtl/fp32_booth_mul.sv - pipelined binary32 multiplier, RNE rounding, flush-to-zero
module fp32_booth_mul
  import fp32_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DWIDTH-1:0] a_operand,
  input  logic [DWIDTH-1:0] b_operand,
  output logic [DWIDTH-1:0] result,
  output logic              Exception,
  output logic              Overflow,
  output logic              Underflow
);

  logic [DWIDTH-1:0] r_a, r_b;

  logic               r_s1_sign;
  logic signed [9:0]  r_s1_esum;
  logic [47:0]        r_s1_prod;
  op_class_e          r_s1_cls_a, r_s1_cls_b;

  logic [EWIDTH-1:0]  w_ea, w_eb;
  logic [MWIDTH-1:0]  w_fa, w_fb;
  logic [23:0]        w_sig_a, w_sig_b;
  logic [47:0]        w_prod;
  logic signed [9:0]  w_esum;

  assign w_ea    = r_a[30:23];
  assign w_eb    = r_b[30:23];
  assign w_fa    = r_a[22:0];
  assign w_fb    = r_b[22:0];
  assign w_sig_a = {(w_ea != '0), w_fa};
  assign w_sig_b = {(w_eb != '0), w_fb};
  assign w_esum  = $signed({2'b00, w_ea}) + $signed({2'b00, w_eb}) - 10'sd127;

  booth_mul_24x24 u_booth (
    .i_a (w_sig_a),
    .i_b (w_sig_b),
    .o_p (w_prod)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a        <= '0;
      r_b        <= '0;
      r_s1_sign  <= 1'b0;
      r_s1_esum  <= '0;
      r_s1_prod  <= '0;
      r_s1_cls_a <= ZERO;
      r_s1_cls_b <= ZERO;
    end else begin
      r_a        <= a_operand;
      r_b        <= b_operand;
      r_s1_sign  <= r_a[31] ^ r_b[31];
      r_s1_esum  <= w_esum;
      r_s1_prod  <= w_prod;
      r_s1_cls_a <= classify(w_ea, w_fa);
      r_s1_cls_b <= classify(w_eb, w_fb);
    end
  end

  logic               w_norm, w_guard, w_sticky, w_round_up;
  logic [MWIDTH-1:0]  w_mant;
  logic [23:0]        w_mant_rnd;
  logic signed [9:0]  w_exp_norm, w_exp_fin;
  logic               w_any_nan, w_any_inf, w_any_zero;
  logic [DWIDTH-1:0]  w_res;
  logic               w_exc, w_ovf, w_unf;

  assign w_norm     = r_s1_prod[47];
  assign w_mant     = w_norm ? r_s1_prod[46:24] : r_s1_prod[45:23];
  assign w_guard    = w_norm ? r_s1_prod[23]    : r_s1_prod[22];
  assign w_sticky   = w_norm ? |r_s1_prod[22:0] : |r_s1_prod[21:0];
  assign w_round_up = w_guard & (w_sticky | w_mant[0]);
  assign w_mant_rnd = {1'b0, w_mant} + {23'd0, w_round_up};
  assign w_exp_norm = r_s1_esum + (w_norm ? 10'sd1 : 10'sd0);
  // A carry out of the rounded mantissa leaves the fraction at zero and bumps the exponent.
  assign w_exp_fin  = w_exp_norm + (w_mant_rnd[23] ? 10'sd1 : 10'sd0);

  assign w_any_nan  = (r_s1_cls_a == NAN)  || (r_s1_cls_b == NAN);
  assign w_any_inf  = (r_s1_cls_a == INF)  || (r_s1_cls_b == INF);
  assign w_any_zero = (r_s1_cls_a == ZERO) || (r_s1_cls_b == ZERO);

  always_comb begin
    w_res = {r_s1_sign, w_exp_fin[7:0], w_mant_rnd[22:0]};
    w_exc = 1'b0;
    w_ovf = 1'b0;
    w_unf = 1'b0;
    if (w_any_nan || (w_any_inf && w_any_zero)) begin
      w_res = QNAN;
      w_exc = 1'b1;
    end else if (w_any_inf) begin
      w_res = {r_s1_sign, EXP_MAX, 23'd0};
      w_exc = 1'b1;
    end else if (w_any_zero) begin
      w_res = {r_s1_sign, 31'd0};
    end else if (w_exp_fin > 10'sd254) begin
      w_res = {r_s1_sign, EXP_MAX, 23'd0};
      w_ovf = 1'b1;
    end else if (w_exp_fin < 10'sd1) begin
      w_res = {r_s1_sign, 31'd0};
      w_unf = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result    <= '0;
      Exception <= 1'b0;
      Overflow  <= 1'b0;
      Underflow <= 1'b0;
    end else begin
      result    <= w_res;
      Exception <= w_exc;
      Overflow  <= w_ovf;
      Underflow <= w_unf;
    end
  end

endmodule

// File: tb/tb_fp32_booth_mul.sv
// tb/tb_fp32_booth_mul.sv - scoreboard bench for fp32_booth_mul
module tb_fp32_booth_mul;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] a_op = '0, b_op = '0;
  logic [31:0] res;
  logic        exc, ovf, unf;

  fp32_booth_mul dut (
    .clk       (clk),
    .rst       (rst),
    .a_operand (a_op),
    .b_operand (b_op),
    .result    (res),
    .Exception (exc),
    .Overflow  (ovf),
    .Underflow (unf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [2:0]  flg;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %08h want %08h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] i2f(input logic s, input int unsigned v);
    int p;
    logic [31:0] m;
    if (v == 0) return {s, 31'd0};
    p = 0;
    for (int k = 0; k < 32; k++) if (v[k]) p = k;
    m = v << (23 - p);
    return {s, 8'(127 + p), m[22:0]};
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      check($sformatf("res@%0d", cyc), res, e.res);
      check($sformatf("flags@%0d", cyc), {29'd0, exc, ovf, unf}, {29'd0, e.flg});
    end
  end

  task automatic drive(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r, input logic [2:0] f);
    @(negedge clk);
    a_op = a;
    b_op = b;
    sb.push_back('{res: r, flg: f, due: cyc + 3});
  endtask

  initial begin
    int unsigned i, j;
    logic sa, sb_s;
    int budget;

    repeat (2) @(negedge clk);
    #1;
    check("reset_res", res, 32'd0);
    check("reset_flags", {29'd0, exc, ovf, unf}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // flags packed as {Exception, Overflow, Underflow}
    drive(32'h42F18000, 32'hC1640000, 32'hC4D71600, 3'b000);
    drive(32'h43F19000, 32'h53F19800, 32'h5863F7FE, 3'b000);
    drive(32'h3FFFFFFF, 32'h3F800001, 32'h40000000, 3'b000);
    drive(32'h7F000000, 32'h7F000000, 32'h7F800000, 3'b010);
    drive(32'h00800000, 32'h00800000, 32'h00000000, 3'b001);
    drive(32'h7FC00000, 32'h3F800000, 32'h7FC00000, 3'b100);
    drive(32'h7F800000, 32'h00000000, 32'h7FC00000, 3'b100);
    drive(32'hFF800000, 32'h40000000, 32'hFF800000, 3'b100);
    drive(32'h80000000, 32'h3F800000, 32'h80000000, 3'b000);
    drive(32'h3F800000, 32'h3F800000, 32'h3F800000, 3'b000);
    drive(32'h00400000, 32'h3F800000, 32'h00000000, 3'b000);

    for (int k = 0; k < 8; k++) begin
      i    = $urandom_range(1, 4095);
      j    = $urandom_range(1, 4095);
      sa   = 1'($urandom_range(0, 1));
      sb_s = 1'($urandom_range(0, 1));
      drive(i2f(sa, i), i2f(sb_s, j), i2f(sa ^ sb_s, i * j), 3'b000);
    end

    drive(32'h7F000000, 32'h7F000000, 32'h7F800000, 3'b010);
    drive(32'h42F18000, 32'hC1640000, 32'hC4D71600, 3'b000);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_res", res, 32'd0);
    check("midrst_flags", {29'd0, exc, ovf, unf}, 32'd0);
    sb.delete();

    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      a_op = 32'h7FC00000;
      b_op = 32'h40000000;
    end
    @(negedge clk);
    rst  = 1'b0;
    a_op = '0;
    b_op = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      check($sformatf("postrst_res%0d", k), res, 32'd0);
      check($sformatf("postrst_flags%0d", k), {29'd0, exc, ovf, unf}, 32'd0);
    end

    drive(32'h42F18000, 32'hC1640000, 32'hC4D71600, 3'b000);
    drive(32'h00000000, 32'h00000000, 32'h00000000, 3'b000);

    budget = 20;
    while (sb.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("drain", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
